// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two requesters using round-robin grant and one result slot per port.
// Ports: clk/rst (sync, active high); reqK_valid/ready/a/b/control accept an operation from requester K;
// respK_valid/ready/result/overflow/zero/equal hold that requester's registered alu result until consumed.
package alu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
   } alu_control_t;
endpackage

// alu: combinational N-bit alu with signed overflow, zero and operand-equal flags.
// Shifts use the full b operand, so amounts of N or more shift everything out.
module alu
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   input  alu_control_t  control,
   output logic [N-1:0]  result,
   output logic          overflow,
   output logic          zero,
   output logic          equal
);
   logic [N-1:0] sum, diff;
   always_comb begin
      sum      = a + b;
      diff     = a - b;
      result   = '0;
      overflow = 1'b0;
      case (control)
         ALU_ADD: begin
            result   = sum;
            overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
         end
         ALU_SUB: begin
            result   = diff;
            overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLT: result = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLL: result = a << b;
         ALU_SRL: result = a >> b;
         ALU_SRA: result = $unsigned($signed(a) >>> b);
         default: result = '0;
      endcase
      zero  = result == '0;
      equal = a == b;
   end
endmodule

module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [N-1:0]  req0_a,
   input  logic [N-1:0]  req0_b,
   input  alu_control_t  req0_control,
   output logic          resp0_valid,
   input  logic          resp0_ready,
   output logic [N-1:0]  resp0_result,
   output logic          resp0_overflow,
   output logic          resp0_zero,
   output logic          resp0_equal,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [N-1:0]  req1_a,
   input  logic [N-1:0]  req1_b,
   input  alu_control_t  req1_control,
   output logic          resp1_valid,
   input  logic          resp1_ready,
   output logic [N-1:0]  resp1_result,
   output logic          resp1_overflow,
   output logic          resp1_zero,
   output logic          resp1_equal
);
   logic          e0, e1, g0, g1;
   logic          last_q, last_d, valid0_q, valid0_d, valid1_q, valid1_d;
   logic [N+2:0]  slot0_q, slot0_d, slot1_q, slot1_d;
   logic [N-1:0]  alu_a, alu_b, alu_res;
   alu_control_t  alu_ctl;
   logic          alu_ovf, alu_zero, alu_eq;

   // A full slot blocks its port even while it is being drained; last_q=1 gives port 0 the next tie.
   always_comb begin
      e0      = req0_valid & ~valid0_q;
      e1      = req1_valid & ~valid1_q;
      g0      = ~rst & e0 & (~e1 | last_q);
      g1      = ~rst & e1 & (~e0 | ~last_q);
      alu_a   = g1 ? req1_a : req0_a;
      alu_b   = g1 ? req1_b : req0_b;
      alu_ctl = g1 ? req1_control : req0_control;
   end

   alu #(.N(N)) u_alu (
      .a(alu_a), .b(alu_b), .control(alu_ctl),
      .result(alu_res), .overflow(alu_ovf), .zero(alu_zero), .equal(alu_eq)
   );

   always_comb begin
      valid0_d = g0 | (valid0_q & ~resp0_ready);
      valid1_d = g1 | (valid1_q & ~resp1_ready);
      slot0_d  = g0 ? {alu_ovf, alu_zero, alu_eq, alu_res} : slot0_q;
      slot1_d  = g1 ? {alu_ovf, alu_zero, alu_eq, alu_res} : slot1_q;
      last_d   = g1 | (~g0 & last_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid0_q <= 1'b0;
         valid1_q <= 1'b0;
         slot0_q  <= '0;
         slot1_q  <= '0;
         last_q   <= 1'b1;
      end else begin
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
         slot0_q  <= slot0_d;
         slot1_q  <= slot1_d;
         last_q   <= last_d;
      end
   end

   assign req0_ready  = g0;
   assign req1_ready  = g1;
   assign resp0_valid = valid0_q;
   assign resp1_valid = valid1_q;
   assign {resp0_overflow, resp0_zero, resp0_equal, resp0_result} = slot0_q;
   assign {resp1_overflow, resp1_zero, resp1_equal, resp1_result} = slot1_q;
endmodule
